// File: rtl/gcd_rr_arbiter.sv
// Round-robin arbiter sharing one gcd_ci custom-instruction unit between
// NUM_REQ requesters. Latches the winner's operands and sequences start/done on
// the unit. Returns the result, or an error response if the unit times out.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   req                 per-requester request level
//   req_a, req_b        packed operands, requester i at [i*DATA_W +: DATA_W]
//   gnt                 one-hot requester currently being served
//   rsp_valid           one-cycle response pulse per requester
//   rsp_result, rsp_err response payload, valid with rsp_valid
//   busy                arbiter not idle
//   gcd_*               connection to the gcd_ci unit
module gcd_rr_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      gcd_clk_en,
   output logic                      gcd_reset,
   output logic                      gcd_start,
   output logic [DATA_W-1:0]         gcd_dataa,
   output logic [DATA_W-1:0]         gcd_datab,
   input  logic                      gcd_done,
   input  logic [DATA_W-1:0]         gcd_result
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FLUSH,
      S_RESP
   } state_t;

   state_t               r_state, w_nxt_state;
   logic [PTR_W-1:0]     r_ptr, w_nxt_ptr;
   logic [NUM_REQ-1:0]   r_gnt, w_nxt_gnt;
   logic [NUM_REQ-1:0]   r_rsp_valid, w_nxt_rsp_valid;
   logic [DATA_W-1:0]    r_rsp_result, w_nxt_rsp_result;
   logic                 r_rsp_err, w_nxt_rsp_err;
   logic                 r_busy, w_nxt_busy;
   logic                 r_start, w_nxt_start;
   logic                 r_flush, w_nxt_flush;
   logic [DATA_W-1:0]    r_dataa, w_nxt_dataa;
   logic [DATA_W-1:0]    r_datab, w_nxt_datab;
   logic [CNT_W-1:0]     r_cnt, w_nxt_cnt;
   logic                 r_done_q;

   logic                 w_found;
   logic [PTR_W-1:0]     w_win;
   logic [PTR_W-1:0]     w_idx;
   logic [NUM_REQ-1:0]   w_win_oh;
   logic [DATA_W-1:0]    w_op_a, w_op_b;
   logic                 w_done_rise;

   // Round-robin search: first active request starting just above the pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_idx = PTR_W'((32'(r_ptr) + k) % NUM_REQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_win_oh    = NUM_REQ'(1) << w_win;
   assign w_op_a      = req_a[32'(w_win) * DATA_W +: DATA_W];
   assign w_op_b      = req_b[32'(w_win) * DATA_W +: DATA_W];
   // Only a fresh edge counts, so a done left high from a previous job is ignored.
   assign w_done_rise = gcd_done && !r_done_q;

   // Next-state and next-output logic.
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_ptr        = r_ptr;
      w_nxt_gnt        = r_gnt;
      w_nxt_rsp_valid  = '0;
      w_nxt_rsp_result = r_rsp_result;
      w_nxt_rsp_err    = 1'b0;
      w_nxt_start      = 1'b0;
      w_nxt_flush      = 1'b0;
      w_nxt_dataa      = r_dataa;
      w_nxt_datab      = r_datab;
      w_nxt_cnt        = r_cnt;

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_nxt_gnt   = w_win_oh;
               w_nxt_ptr   = w_win;
               w_nxt_dataa = w_op_a;
               w_nxt_datab = w_op_b;
               // gcd(x,0) = x and gcd(0,0) = 0: answer directly without the unit.
               if ((w_op_a == '0) || (w_op_b == '0)) begin
                  w_nxt_state      = S_RESP;
                  w_nxt_rsp_valid  = w_win_oh;
                  w_nxt_rsp_result = w_op_a | w_op_b;
               end else begin
                  w_nxt_state = S_ISSUE;
                  w_nxt_start = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_done_rise) begin
               w_nxt_state      = S_RESP;
               w_nxt_rsp_valid  = r_gnt;
               w_nxt_rsp_result = gcd_result;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               w_nxt_state = S_FLUSH;
               w_nxt_flush = 1'b1;
               w_nxt_cnt   = '0;
            end else if (r_cnt != CNT_W'(TIMEOUT_CYC)) begin
               w_nxt_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_FLUSH: begin
            // Counter reused to hold the unit in reset for two cycles.
            if (r_cnt == CNT_W'(1)) begin
               w_nxt_state      = S_RESP;
               w_nxt_rsp_valid  = r_gnt;
               w_nxt_rsp_err    = 1'b1;
               w_nxt_rsp_result = '0;
            end else begin
               w_nxt_flush = 1'b1;
               w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            w_nxt_gnt   = '0;
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_gnt   = '0;
         end
      endcase

      w_nxt_busy = (w_nxt_state != S_IDLE);
   end

   // State and output registers; done history is tracked even during reset.
   always_ff @(posedge clk) begin
      r_done_q <= gcd_done;
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= PTR_W'(NUM_REQ - 1);
         r_gnt        <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
         r_busy       <= 1'b0;
         r_start      <= 1'b0;
         r_flush      <= 1'b0;
         r_dataa      <= '0;
         r_datab      <= '0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_ptr        <= w_nxt_ptr;
         r_gnt        <= w_nxt_gnt;
         r_rsp_valid  <= w_nxt_rsp_valid;
         r_rsp_result <= w_nxt_rsp_result;
         r_rsp_err    <= w_nxt_rsp_err;
         r_busy       <= w_nxt_busy;
         r_start      <= w_nxt_start;
         r_flush      <= w_nxt_flush;
         r_dataa      <= w_nxt_dataa;
         r_datab      <= w_nxt_datab;
         r_cnt        <= w_nxt_cnt;
      end
   end

   assign gnt        = r_gnt;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;
   assign busy       = r_busy;
   assign gcd_clk_en = 1'b1;
   // Unit is held in reset while the arbiter is, and during a timeout flush.
   assign gcd_reset  = r_flush | ~reset_n;
   assign gcd_start  = r_start;
   assign gcd_dataa  = r_dataa;
   assign gcd_datab  = r_datab;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// Self-checking bench for gcd_rr_arbiter with a behavioural gcd_ci model and a
// response scoreboard.
module tb_gcd_rr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 64;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*DW-1:0]  req_a = '0;
   logic [NR*DW-1:0]  req_b = '0;
   logic [NR-1:0]     gnt, rsp_valid;
   logic [DW-1:0]     rsp_result;
   logic              rsp_err, busy, gcd_clk_en, gcd_reset, gcd_start;
   logic [DW-1:0]     gcd_dataa, gcd_datab;
   logic              gcd_done;
   logic [DW-1:0]     gcd_result;

   // gcd_ci model state
   logic              m_done = 1'b0;
   logic              m_busy = 1'b0;
   logic [DW-1:0]     m_res = '0;
   int                m_cnt = 0;
   int                n_start = 0;
   logic              hang = 1'b0;
   logic              stale = 1'b0;

   exp_t              sb[$];
   int                n_chk = 0;
   int                n_fail = 0;
   int                ncyc = 0;
   int                edge_cyc = 0;
   int                rsp_cyc = 0;
   int                rst_cyc = 0;
   int                n_rsp = 0;
   logic              prev_done = 1'b0;

   always #5 clk = ~clk;

   gcd_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .busy(busy), .gcd_clk_en(gcd_clk_en), .gcd_reset(gcd_reset),
      .gcd_start(gcd_start), .gcd_dataa(gcd_dataa), .gcd_datab(gcd_datab),
      .gcd_done(gcd_done), .gcd_result(gcd_result)
   );

   function automatic logic [31:0] gcd_f(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Unit model: done rises 4 cycles after start and stays high until next start/reset.
   always @(posedge clk) begin
      if (gcd_reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (gcd_start) begin
         m_res   <= gcd_f(gcd_dataa, gcd_datab);
         m_cnt   <= 3;
         m_busy  <= !hang;
         m_done  <= 1'b0;
         n_start <= n_start + 1;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   assign gcd_done   = m_done | stale;
   assign gcd_result = m_res;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: sample at negedge, score responses, drop served requests.
   task automatic step();
      exp_t e;
      @(negedge clk);
      ncyc++;
      if (gcd_done && !prev_done) edge_cyc = ncyc;
      prev_done = gcd_done;
      if (gcd_reset && reset_n) rst_cyc++;
      if (rsp_valid != '0) begin
         n_rsp++;
         rsp_cyc = ncyc;
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_idx", 64'(rsp_valid), 64'(NR'(1) << e.idx));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_gnt", 64'(gnt), 64'(rsp_valid));
         end
         req = req & ~rsp_valid;
      end
   endtask

   task automatic launch(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic err);
      exp_t e;
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req[i] = 1'b1;
      e.idx = i;
      e.res = res;
      e.err = err;
      sb.push_back(e);
   endtask

   task automatic wait_empty(input int maxc);
      int n;
      n = 0;
      while (sb.size() != 0 && n < maxc) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         chk("wait_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      step();
      step();
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_gnt"}, 64'(gnt), 64'd0);
      chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
      chk({pfx, "_busy"}, 64'(busy), 64'd0);
      chk({pfx, "_start"}, 64'(gcd_start), 64'd0);
      chk({pfx, "_result"}, 64'(rsp_result), 64'd0);
      chk({pfx, "_dataa"}, 64'(gcd_dataa), 64'd0);
      chk({pfx, "_datab"}, 64'(gcd_datab), 64'd0);
      chk({pfx, "_clk_en"}, 64'(gcd_clk_en), 64'd1);
      chk({pfx, "_gcd_reset"}, 64'(gcd_reset), 64'd1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, c0, r0;
      logic [31:0] a, b;

      // Reset values
      reset_n = 1'b0;
      step();
      step();
      chk_reset_vals("rst");
      reset_n = 1'b1;
      step();

      // T1: single request, start one cycle after req
      launch(0, 32'd91, 32'd21, 32'd7, 1'b0);
      step();
      chk("t1_start", 64'(gcd_start), 64'd1);
      chk("t1_gnt", 64'(gnt), 64'd1);
      chk("t1_dataa", 64'(gcd_dataa), 64'd91);
      step();
      chk("t1_start_once", 64'(gcd_start), 64'd0);
      wait_empty(50);
      chk("t1_rsp_lat", 64'(rsp_cyc), 64'(edge_cyc + 1));

      // T2: all four at once from fresh pointer, then 0 and 3
      do_reset();
      for (int i = 0; i < 4; i++) launch(i, 32'd1000000000, 32'd2, 32'd2, 1'b0);
      wait_empty(400);
      launch(0, 32'd1000000000, 32'd2, 32'd2, 1'b0);
      launch(3, 32'd1000000000, 32'd2, 32'd2, 1'b0);
      wait_empty(200);

      // T3: zero-operand bypass
      s0 = n_start;
      c0 = ncyc;
      launch(1, 32'd0, 32'd1023, 32'd1023, 1'b0);
      wait_empty(20);
      chk("t3_lat", 64'(rsp_cyc - c0), 64'd1);
      launch(1, 32'd0, 32'd0, 32'd0, 1'b0);
      wait_empty(20);
      chk("t3_no_start", 64'(n_start), 64'(s0));

      // T4: unit timeout, flush and error response
      hang = 1'b1;
      rst_cyc = 0;
      c0 = ncyc;
      launch(2, 32'd5, 32'd10, 32'd0, 1'b1);
      wait_empty(TO + 20);
      chk("t4_lat", 64'(rsp_cyc - c0), 64'(TO + 4));
      chk("t4_flush_cyc", 64'(rst_cyc), 64'd2);
      hang = 1'b0;
      launch(0, 32'd2147483647, 32'd524287, 32'd1, 1'b0);
      wait_empty(50);

      // T5: reset during WAIT with a stale done held high afterwards
      hang = 1'b1;
      req_a[3*DW +: DW] = 32'd12;
      req_b[3*DW +: DW] = 32'd18;
      req[3] = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("t5_in_wait", 64'(busy), 64'd1);
      reset_n = 1'b0;
      stale = 1'b1;
      req[3] = 1'b0;
      step();
      chk_reset_vals("t5");
      reset_n = 1'b1;
      hang = 1'b0;
      r0 = n_rsp;
      for (int i = 0; i < 6; i++) step();
      chk("t5_no_rsp", 64'(n_rsp - r0), 64'd0);
      chk("t5_idle", 64'(busy), 64'd0);
      launch(3, 32'd12, 32'd18, 32'd6, 1'b0);
      step();
      chk("t5_start", 64'(gcd_start), 64'd1);
      step();
      chk("t5_stale_ignored", 64'(rsp_valid), 64'd0);
      stale = 1'b0;
      wait_empty(50);

      // T6: operands changed after grant are ignored
      launch(1, 32'd48, 32'd36, 32'd12, 1'b0);
      step();
      req_a[1*DW +: DW] = 32'd35;
      req_b[1*DW +: DW] = 32'd14;
      step();
      chk("t6_dataa", 64'(gcd_dataa), 64'd48);
      wait_empty(50);

      // Random single jobs
      for (int k = 0; k < 6; k++) begin
         a = 32'($urandom_range(1, 65535));
         b = 32'($urandom_range(1, 65535));
         launch(int'($urandom_range(0, 3)), a, b, gcd_f(a, b), 1'b0);
         wait_empty(100);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
